i2c_cfg_sequencer: RTL and testbench
====================================

# i2c_cfg_sequencer

Serialises one 24-bit configuration word into an I2C write transaction to the audio codec: device address + W, register byte, data byte. It sits between the HPS-controlled PIOs and the FPGA I2C pins. The PIOs are `i2c_data_0` (24-bit word), `i2c_start_flag_0` (start level) and `i2c_end_flag_0` (done level). Software writes the word, raises start, polls end, then lowers start.

## Interface
- `CLK_DIV`, default 125: clock cycles per SCL quarter-period. 125 at 50 MHz gives 100 kHz SCL. Legal range is 2 or greater.

- `clk_50`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `i2c_data`  in  24  [23:16] device address + R/W bit, [15:8] register, [7:0] data
- `i2c_start`  in  1  start request level from PIO
- `i2c_end`  out  1  transaction-complete level to PIO
- `ack_err`  out  1  sticky: a NACK was seen in the last transaction
- `busy`  out  1  transaction in progress
- `i2c_scl`  out  1  SCL, push-pull
- `sda_oe`  out  1  1 = pull SDA low; 0 = release SDA (top level builds the open-drain inout)
- `sda_in`  in  1  sampled SDA pin

Clock and reset: one clock, `clk_50`; reset is asynchronous, active-low, `reset_n`.

## Operation
- **Quarter tick:** a counter runs 0..CLK_DIV-1 only while busy. A tick fires on the terminal count, then the counter wraps to 0.
- **Slot:** 4 quarters, Q0..Q3.
- **Start acceptance:** 1-cycle delayed copy of `i2c_start` gives a rising-edge detect. A rising edge in IDLE is accepted. On acceptance:
  - `i2c_data` is latched into a 24-bit shift register;
  - `ack_err` clears;
  - `busy` sets;
  - state goes to START.
- Rising edges while busy, or while `i2c_end`=1, are ignored.
- **States:** IDLE → START → BIT → ACK → (BIT | STOP) → DONE → IDLE.
- **START (1 slot):**
  - Q0–Q1: SCL=1, SDA released.
  - Q2–Q3: SCL=1, SDA low.
- **BIT (8 slots per byte, MSB first, bit 23 first):**
  - Q0: SCL=0; SDA drives the bit (`sda_oe` = ~bit).
  - Q1: SCL=0.
  - Q2–Q3: SCL=1.
  - The register shifts left at the end of Q3.
- **ACK (1 slot after each byte):**
  - SDA released; same SCL pattern as BIT.
  - `sda_in` is sampled on the last cycle of Q2.
  - 0 = ACK: continue to the next byte, or to STOP after byte 3.
  - 1 = NACK: set `ack_err` and go straight to STOP; remaining bytes are skipped.
- **STOP (1 slot):**
  - Q0: SCL=0, SDA low.
  - Q1: SCL=1, SDA low.
  - Q2–Q3: SCL=1, SDA released.
- **DONE:**
  - `busy`=0 and `i2c_end`=1.
  - Held until `i2c_start`=0, then the block returns to IDLE and clears `i2c_end` in the same cycle.
  - If `i2c_start` is already 0 on entry to DONE, IDLE follows on the next cycle.
- **Idle bus:** SCL=1, `sda_oe`=0.
- **Reset asserted at any time, including mid-transaction:**
  - asynchronous return to IDLE;
  - SCL=1, `sda_oe`=0, `i2c_end`=0, `ack_err`=0, `busy`=0;
  - counters and shift register zeroed.
- **After reset release:** a start level already high is not a rising edge. The edge detector resets to 1 for this reason, so software must toggle start.

## Timing
- **Reset values:** `i2c_scl`=1, `sda_oe`=0, `i2c_end`=0, `ack_err`=0, `busy`=0.
- **`busy` rise:** the cycle after the rising edge of `i2c_start` is registered.
- **Full transaction:** 1 + 9 + 9 + 9 + 1 = 29 slots = 116 quarters = 116·CLK_DIV cycles from `busy` rise to `i2c_end` rise.
- **NACK on byte n (n = 1..3):** 1 + 9n slots, then STOP (1 slot). Total (9n+2)·4·CLK_DIV cycles.
- **Output changes:** SCL/SDA change only on the first cycle of a quarter. All outputs are registered, with no combinational path from input to output.
- **ACK sample point:** the last cycle of Q2 (mid-SCL-high).
- **`i2c_end` fall:** the cycle after `i2c_start`=0 is seen in DONE.

## Test plan
- **Nominal write:** CLK_DIV=4, data=0x341E00, slave ACKs all three bytes.
  - SDA bit stream at SCL rises is 0011_0100 ACK 0001_1110 ACK 0000_0000 ACK.
  - `i2c_end`=1 exactly 464 cycles after `busy` rise.
  - `ack_err`=0.
- **Address NACK:** `sda_in` held 1.
  - `ack_err`=1 after slot 10; STOP follows immediately.
  - `i2c_end` at 11·16 = 176 cycles.
  - No register or data bits are driven.
- **Data-byte NACK:** NACK only on byte 3.
  - `ack_err`=1; `i2c_end` at 29 slots (116·4 cycles).
- **Handshake:** start held high through DONE.
  - Exactly one transaction; `i2c_end` stays 1.
  - Start low → `i2c_end`=0 next cycle.
  - Start high again → second transaction, with `ack_err` cleared.
- **Start during busy:** pulse `i2c_start` low then high mid-transaction.
  - Ignored: one transaction only, and the timing is unchanged.
- **Reset mid-operation:** assert `reset_n`=0 during byte 2.
  - Outputs are SCL=1, `sda_oe`=0, `busy`=0 within the same cycle.
  - After release with start still high, no transaction starts until start is toggled.

Source files
------------

// File: rtl/i2c_cfg_sequencer_if.sv
// i2c_cfg_sequencer_if
//   Groups the PIO handshake and the I2C pin signals of the codec
//   configuration sequencer.
//   master : PIO / pin side (drives word, start level and sampled SDA)
//   slave  : sequencer side (drives end/ack_err/busy and SCL/SDA enable)
// Signals:
//   i2c_data  [23:0] device address + R/W, register, data
//   i2c_start        start request level
//   i2c_end          transaction-complete level
//   ack_err          sticky NACK flag for the last transaction
//   busy             transaction in progress
//   i2c_scl          SCL, push-pull
//   sda_oe           1 = pull SDA low, 0 = release SDA
//   sda_in           sampled SDA pin
interface i2c_cfg_sequencer_if;
    logic [23:0] i2c_data;
    logic        i2c_start;
    logic        i2c_end;
    logic        ack_err;
    logic        busy;
    logic        i2c_scl;
    logic        sda_oe;
    logic        sda_in;

    modport master (
        output i2c_data, i2c_start, sda_in,
        input  i2c_end, ack_err, busy, i2c_scl, sda_oe
    );

    modport slave (
        input  i2c_data, i2c_start, sda_in,
        output i2c_end, ack_err, busy, i2c_scl, sda_oe
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer
//   Serialises one 24-bit configuration word into an I2C write:
//   START, address+W byte, register byte, data byte (each followed by an
//   ACK slot), STOP. A NACK aborts straight to STOP and sets ack_err.
//   Each bit slot is four quarters of CLK_DIV clocks; SCL/SDA only change
//   on the first cycle of a quarter and every output is registered.
// Ports:
//   clk_50   system clock
//   reset_n  asynchronous active-low reset
//   bus      i2c_cfg_sequencer_if.slave (PIO handshake + SCL/SDA)
// Parameters:
//   CLK_DIV  clocks per SCL quarter period (>= 2)
module i2c_cfg_sequencer #(
    parameter int CLK_DIV = 125
) (
    input  logic                  clk_50,
    input  logic                  reset_n,
    i2c_cfg_sequencer_if.slave    bus
);

    localparam int            CW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] QLAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [23:0]   shreg;
    logic          start_d;
    logic          scl_r;
    logic          sda_oe_r;
    logic          end_r;
    logic          err_r;
    logic          busy_r;

    logic tick;
    logic start_rise;

    // tick marks the last cycle of a quarter; state/output updates made on
    // it therefore land on the first cycle of the next quarter.
    assign tick       = busy_r && (qcnt == QLAST);
    assign start_rise = bus.i2c_start && !start_d;

    assign bus.i2c_scl = scl_r;
    assign bus.sda_oe  = sda_oe_r;
    assign bus.i2c_end = end_r;
    assign bus.ack_err = err_r;
    assign bus.busy    = busy_r;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            qcnt     <= '0;
            quarter  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            // A start level already high when reset releases must not
            // look like a rising edge.
            start_d  <= 1'b1;
            scl_r    <= 1'b1;
            sda_oe_r <= 1'b0;
            end_r    <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            start_d <= bus.i2c_start;

            if (busy_r) begin
                qcnt <= tick ? '0 : qcnt + 1'b1;
            end
            if (tick) begin
                quarter <= quarter + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        shreg    <= bus.i2c_data;
                        err_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        state    <= S_START;
                    end
                end

                // SCL stays high; SDA falls at the start of Q2.
                S_START: begin
                    if (tick) begin
                        case (quarter)
                            2'd1: sda_oe_r <= 1'b1;
                            2'd3: begin
                                state    <= S_BIT;
                                scl_r    <= 1'b0;
                                sda_oe_r <= ~shreg[23];
                            end
                            default: ;
                        endcase
                    end
                end

                S_BIT: begin
                    if (tick) begin
                        case (quarter)
                            2'd1: scl_r <= 1'b1;
                            2'd3: begin
                                shreg <= shreg << 1;
                                scl_r <= 1'b0;
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt  <= '0;
                                    sda_oe_r <= 1'b0;
                                    state    <= S_ACK;
                                end else begin
                                    bit_cnt  <= bit_cnt + 1'b1;
                                    // shreg[22] is the bit that becomes the
                                    // MSB after this shift.
                                    sda_oe_r <= ~shreg[22];
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                // err_r was cleared on acceptance and only a NACK sets it,
                // so it doubles as the "abort to STOP" flag.
                S_ACK: begin
                    if (tick) begin
                        case (quarter)
                            2'd1: scl_r <= 1'b1;
                            2'd2: begin
                                if (bus.sda_in) begin
                                    err_r <= 1'b1;
                                end
                            end
                            2'd3: begin
                                scl_r <= 1'b0;
                                if (err_r || byte_cnt == 2'd2) begin
                                    sda_oe_r <= 1'b1;
                                    state    <= S_STOP;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                    sda_oe_r <= ~shreg[23];
                                    state    <= S_BIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                // SCL rises with SDA low, then SDA is released while SCL high.
                S_STOP: begin
                    if (tick) begin
                        case (quarter)
                            2'd0: scl_r    <= 1'b1;
                            2'd1: sda_oe_r <= 1'b0;
                            2'd3: begin
                                busy_r <= 1'b0;
                                end_r  <= 1'b1;
                                state  <= S_DONE;
                            end
                            default: ;
                        endcase
                    end
                end

                S_DONE: begin
                    if (!bus.i2c_start) begin
                        end_r <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer
//   Scoreboard bench for i2c_cfg_sequencer with CLK_DIV = 4. The driver
//   pushes the expected SDA level at every SCL rise, the expected
//   busy-to-end latency and the expected ack_err; a negedge monitor with
//   a small slave model pops and compares them as the DUT produces them.
module tb_i2c_cfg_sequencer;

    localparam int CD = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    i2c_cfg_sequencer_if bus();

    i2c_cfg_sequencer #(.CLK_DIV(CD)) dut (
        .clk_50  (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic exp_bits[$];
    int   exp_lat[$];
    logic exp_err[$];

    logic [2:0] nack_cfg = 3'b000;
    logic       scl_q, busy_q, end_q;
    logic       active = 1'b0;
    int         cyc = 0;
    int         rise_cnt = 0;
    logic       line_v;
    logic       eb;
    int         el;
    logic       ee;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected bus bits: 8 data bits + ACK level per byte, abort after a
    // NACK, then the STOP rise which happens with SDA held low.
    task automatic push_txn(input logic [23:0] d, input logic [2:0] nk);
        int   nbytes;
        logic err;
        nbytes = 3;
        err    = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) exp_bits.push_back(d[23 - 8*b - i]);
            exp_bits.push_back(nk[b]);
            if (nk[b]) begin
                err    = 1'b1;
                nbytes = b + 1;
                break;
            end
        end
        exp_bits.push_back(1'b0);
        exp_lat.push_back((9*nbytes + 2) * 4 * CD);
        exp_err.push_back(err);
        nack_cfg = nk;
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (!bus.i2c_end && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("end_seen", bus.i2c_end, 1);
    endtask

    task automatic wait_busy(input int bound);
        int n = 0;
        while (!bus.busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("busy_seen", bus.busy, 1);
    endtask

    task automatic run_txn(input logic [23:0] d, input logic [2:0] nk);
        push_txn(d, nk);
        bus.i2c_data  = d;
        bus.i2c_start = 1'b1;
        wait_end(4000);
        bus.i2c_start = 1'b0;
        @(negedge clk);
        check("end_clear", bus.i2c_end, 0);
        @(negedge clk);
    endtask

    // Monitor + slave: samples the bus away from the active edge, drives
    // the ACK/NACK level during each ACK slot, and scores every SCL rise
    // and every completed transaction.
    always @(negedge clk) begin
        if (!reset_n) begin
            active     = 1'b0;
            rise_cnt   = 0;
            bus.sda_in = 1'b1;
        end else begin
            if (active) cyc++;
            if (bus.busy && !busy_q) begin
                active   = 1'b1;
                cyc      = 0;
                rise_cnt = 0;
            end
            if (active && bus.i2c_scl && !scl_q) begin
                line_v = bus.sda_oe ? 1'b0 : bus.sda_in;
                check("bit_pending", exp_bits.size() > 0, 1);
                if (exp_bits.size() > 0) begin
                    eb = exp_bits.pop_front();
                    check($sformatf("bit%0d", rise_cnt), line_v, eb);
                end
                rise_cnt++;
            end
            if (active && !bus.i2c_scl && scl_q) begin
                if (rise_cnt % 9 == 8 && rise_cnt < 27)
                    bus.sda_in = nack_cfg[rise_cnt / 9];
                else
                    bus.sda_in = 1'b1;
            end
            if (bus.i2c_end && !end_q) begin
                check("txn_pending", exp_lat.size() > 0, 1);
                if (exp_lat.size() > 0) begin
                    el = exp_lat.pop_front();
                    ee = exp_err.pop_front();
                    check("latency", cyc, el);
                    check("ack_err", bus.ack_err, ee);
                end
                active = 1'b0;
            end
        end
        scl_q  = bus.i2c_scl;
        busy_q = bus.busy;
        end_q  = bus.i2c_end;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n       = 1'b0;
        bus.i2c_start = 1'b0;
        bus.i2c_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_scl",  bus.i2c_scl, 1);
        check("rst_oe",   bus.sda_oe,  0);
        check("rst_end",  bus.i2c_end, 0);
        check("rst_err",  bus.ack_err, 0);
        check("rst_busy", bus.busy,    0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal write, address NACK, data-byte NACK.
        run_txn(24'h341E00, 3'b000);
        run_txn(24'h341E00, 3'b001);
        run_txn(24'hA5C35A, 3'b100);

        // Handshake: start held high through DONE.
        push_txn(24'h1234AB, 3'b010);
        bus.i2c_data  = 24'h1234AB;
        bus.i2c_start = 1'b1;
        wait_end(4000);
        repeat (20) @(negedge clk);
        check("hold_end",  bus.i2c_end, 1);
        check("hold_busy", bus.busy,    0);
        check("hold_err",  bus.ack_err, 1);
        bus.i2c_start = 1'b0;
        @(negedge clk);
        check("hs_end_fall",   bus.i2c_end, 0);
        check("hs_err_sticky", bus.ack_err, 1);
        push_txn(24'h5A0F3C, 3'b000);
        bus.i2c_data  = 24'h5A0F3C;
        bus.i2c_start = 1'b1;
        wait_busy(10);
        check("hs_err_cleared", bus.ack_err, 0);
        wait_end(4000);
        bus.i2c_start = 1'b0;
        repeat (2) @(negedge clk);

        // Start toggled mid-transaction must be ignored.
        push_txn(24'h9C6633, 3'b000);
        bus.i2c_data  = 24'h9C6633;
        bus.i2c_start = 1'b1;
        repeat (100) @(negedge clk);
        bus.i2c_start = 1'b0;
        repeat (3) @(negedge clk);
        bus.i2c_start = 1'b1;
        wait_end(4000);
        repeat (30) @(negedge clk);
        check("retrig_end",  bus.i2c_end, 1);
        check("retrig_busy", bus.busy,    0);
        bus.i2c_start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during byte 2, start left high.
        push_txn(24'h3C55F0, 3'b000);
        bus.i2c_data  = 24'h3C55F0;
        bus.i2c_start = 1'b1;
        wait_busy(10);
        @(negedge clk);
        n = 0;
        while (rise_cnt < 12 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_byte2", rise_cnt >= 12, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_scl",  bus.i2c_scl, 1);
        check("mid_rst_oe",   bus.sda_oe,  0);
        check("mid_rst_busy", bus.busy,    0);
        check("mid_rst_end",  bus.i2c_end, 0);
        exp_bits.delete();
        exp_lat.delete();
        exp_err.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("no_restart_busy", bus.busy,    0);
        check("no_restart_end",  bus.i2c_end, 0);
        bus.i2c_start = 1'b0;
        repeat (2) @(negedge clk);
        run_txn(24'hC3817E, 3'b000);

        check("queues_empty", exp_bits.size() + exp_lat.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
